// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter.
//   arb_state_t   : arbiter FSM encoding (IDLE, SETUP, ACCESS, RESP)
//   TIMEOUT_RDATA : read data returned upstream when the downstream watchdog fires
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate-priority-encode of a request vector.
// The search starts one position after the last grant and wraps at N.
//   req   [N]          : request bits
//   last  [$clog2(N)]  : index of the previously granted requester
//   grant [$clog2(N)]  : index of the winner (0 when no request)
//   valid              : at least one request present
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);

    localparam int unsigned IdW = $clog2(N);

    // Index k positions after base, wrapping at N (N need not be a power of two).
    function automatic logic [IdW-1:0] step_from(input logic [IdW-1:0] base,
                                                 input int unsigned   k);
        int unsigned idx;
        idx = 32'(base) + k;
        if (idx >= N) begin
            idx = idx - N;
        end
        return IdW'(idx);
    endfunction

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!valid && req[step_from(last, k)]) begin
                grant = step_from(last, k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter sharing one downstream APB completer between NUM_REQ
// upstream APB requesters. One transfer is in flight at a time; both sides are
// fully registered so the block doubles as a pipeline stage.
//
// Ports:
//   clk, rst          : clock (also the downstream pclk), synchronous active-high reset
//   up_*              : upstream completer ports, one slot per requester
//   down_*            : downstream requester port
//   grant_id          : current/last granted requester (debug)
//   busy              : high whenever the FSM is not IDLE
//   timeout_flag      : sticky ACCESS watchdog flag (only with APB_ARB_TIMEOUT_EN)
//
// Build option: define APB_ARB_TIMEOUT_EN to add the ACCESS watchdog of
// TIMEOUT_CYCLES cycles and the timeout_flag port.
module apb_requester_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    // upstream
    input  logic [NUM_REQ-1:0]           up_psel,
    input  logic [NUM_REQ-1:0]           up_penable,
    input  logic [ADDR_WIDTH-1:0]        up_paddr   [NUM_REQ],
    input  logic [NUM_REQ-1:0]           up_pwrite,
    input  logic [DATA_WIDTH-1:0]        up_pwdata  [NUM_REQ],
    input  logic [DATA_WIDTH/8-1:0]      up_pstrb   [NUM_REQ],
    input  logic [2:0]                   up_pprot   [NUM_REQ],
    output logic [NUM_REQ-1:0]           up_pready,
    output logic [DATA_WIDTH-1:0]        up_prdata  [NUM_REQ],
    output logic [NUM_REQ-1:0]           up_pslverr,
    // downstream
    output logic                         down_psel,
    output logic                         down_penable,
    output logic [ADDR_WIDTH-1:0]        down_paddr,
    output logic                         down_pwrite,
    output logic [DATA_WIDTH-1:0]        down_pwdata,
    output logic [DATA_WIDTH/8-1:0]      down_pstrb,
    output logic [2:0]                   down_pprot,
    input  logic                         down_pready,
    input  logic [DATA_WIDTH-1:0]        down_prdata,
    input  logic                         down_pslverr,
    // status
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
`ifdef APB_ARB_TIMEOUT_EN
    ,
    output logic                         timeout_flag
`endif
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_requester_arbiter: DATA_WIDTH must be 32");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("apb_requester_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // Upstream penable carries no information here: psel alone requests.
    logic unused_penable;
    assign unused_penable = ^up_penable;

    arb_state_t         state;
    logic [IdW-1:0]     last_grant;
    logic [IdW-1:0]     arb_grant;
    logic               arb_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req   (up_psel),
        .last  (last_grant),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Completion of the ACCESS phase and the response it returns upstream.
    logic                  access_done;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TCntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCntW-1:0] tcnt;
    logic             timed_out;
`endif

    always_comb begin
        access_done = down_pready;
        resp_rdata  = down_prdata;
        resp_err    = down_pslverr;
`ifdef APB_ARB_TIMEOUT_EN
        timed_out = !down_pready && (tcnt == TCntW'(TIMEOUT_CYCLES - 1));
        if (timed_out) begin
            access_done = 1'b1;
            resp_rdata  = DATA_WIDTH'(TIMEOUT_RDATA);
            resp_err    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= IdW'(NUM_REQ - 1);
            grant_id     <= '0;
            down_psel    <= 1'b0;
            down_penable <= 1'b0;
            down_paddr   <= '0;
            down_pwrite  <= 1'b0;
            down_pwdata  <= '0;
            down_pstrb   <= '0;
            down_pprot   <= '0;
            up_pready    <= '0;
            up_pslverr   <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                up_prdata[i] <= '0;
            end
`ifdef APB_ARB_TIMEOUT_EN
            tcnt         <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        down_paddr  <= up_paddr[arb_grant];
                        down_pwrite <= up_pwrite[arb_grant];
                        down_pwdata <= up_pwdata[arb_grant];
                        down_pstrb  <= up_pstrb[arb_grant];
                        down_pprot  <= up_pprot[arb_grant];
                        down_psel   <= 1'b1;
                        grant_id    <= arb_grant;
                        last_grant  <= arb_grant;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    down_penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    tcnt <= '0;
`endif
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (access_done) begin
                        down_psel             <= 1'b0;
                        down_penable          <= 1'b0;
                        up_pready[grant_id]   <= 1'b1;
                        up_pslverr[grant_id]  <= resp_err;
                        up_prdata[grant_id]   <= resp_rdata;
                        state                 <= RESP;
`ifdef APB_ARB_TIMEOUT_EN
                        if (timed_out) begin
                            timeout_flag <= 1'b1;
                        end
`endif
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // Requester still holds psel this cycle; returning to IDLE only
                    // afterwards keeps the finished transfer from being re-granted.
                    up_pready  <= '0;
                    up_pslverr <= '0;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        up_prdata[i] <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Randomized self-checking bench for apb_requester_arbiter (3 requesters).
// Requesters issue random transfers, occasionally abandon a granted one, and the
// downstream completer inserts random wait states; random resets hit any phase.
// A transaction-level model predicts the phase windows, round-robin winner and
// the response routed back to each requester.
module tb_apb_requester_arbiter;

    localparam int NR   = 3;
    localparam int AW   = 16;
    localparam int NCYC = 4000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   up_psel, up_penable, up_pwrite, up_pready, up_pslverr;
    logic [AW-1:0]   up_paddr  [NR];
    logic [31:0]     up_pwdata [NR];
    logic [3:0]      up_pstrb  [NR];
    logic [2:0]      up_pprot  [NR];
    logic [31:0]     up_prdata [NR];
    logic            down_psel, down_penable, down_pwrite, down_pready, down_pslverr;
    logic [AW-1:0]   down_paddr;
    logic [31:0]     down_pwdata, down_prdata;
    logic [3:0]      down_pstrb;
    logic [2:0]      down_pprot;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef APB_ARB_TIMEOUT_EN
    logic            timeout_flag;
`endif

    always #5 clk = ~clk;

    apb_requester_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .up_psel      (up_psel),
        .up_penable   (up_penable),
        .up_paddr     (up_paddr),
        .up_pwrite    (up_pwrite),
        .up_pwdata    (up_pwdata),
        .up_pstrb     (up_pstrb),
        .up_pprot     (up_pprot),
        .up_pready    (up_pready),
        .up_prdata    (up_prdata),
        .up_pslverr   (up_pslverr),
        .down_psel    (down_psel),
        .down_penable (down_penable),
        .down_paddr   (down_paddr),
        .down_pwrite  (down_pwrite),
        .down_pwdata  (down_pwdata),
        .down_pstrb   (down_pstrb),
        .down_pprot   (down_pprot),
        .down_pready  (down_pready),
        .down_prdata  (down_prdata),
        .down_pslverr (down_pslverr),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef APB_ARB_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester-side model: one pending transfer per requester.
    bit          act     [NR];
    int          age     [NR];
    logic [AW-1:0] m_addr  [NR];
    bit          m_write [NR];
    logic [31:0] m_wdata [NR];
    logic [3:0]  m_strb  [NR];
    logic [2:0]  m_prot  [NR];

    // Transfer in flight: winner g, granted in cycle s, w downstream wait states.
    bit          inflight;
    bit          aborted;
    int          g, s, w;
    logic [AW-1:0] t_addr;
    bit          t_write;
    logic [31:0] t_wdata;
    logic [3:0]  t_strb;
    logic [2:0]  t_prot;
    logic [31:0] resp_data;
    bit          resp_err;
    int          last_g, exp_grant, next_idle, release_req;
    bit          after_reset;

    function automatic int rr_pick(input bit [NR-1:0] r, input int lst);
        for (int k = 1; k <= NR; k++) begin
            if (r[(lst + k) % NR]) return (lst + k) % NR;
        end
        return -1;
    endfunction

    task automatic new_txn(input int i);
        act[i]     = 1'b1;
        age[i]     = 0;
        m_addr[i]  = AW'($urandom);
        m_write[i] = 1'($urandom);
        m_wdata[i] = $urandom;
        m_strb[i]  = m_write[i] ? 4'($urandom) : 4'h0;
        m_prot[i]  = 3'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        up_psel = '0; up_penable = '0; up_pwrite = '0;
        for (int i = 0; i < NR; i++) begin
            up_paddr[i] = '0; up_pwdata[i] = '0; up_pstrb[i] = '0; up_pprot[i] = '0;
            act[i] = 1'b0; age[i] = 0;
        end
        down_pready = 1'b0; down_prdata = '0; down_pslverr = 1'b0;
        inflight = 1'b0; aborted = 1'b0; g = 0; s = 0; w = 0;
        last_g = NR - 1; exp_grant = 0; next_idle = 0; release_req = -1; after_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int t = 0; t < NCYC; t++) begin
            bit in_setup, in_access, in_resp, rst_now;
            int hold;
            logic [NR-1:0] exp_rdy, exp_err;
            bit [NR-1:0] rv;

            if (t != 0) begin
                @(posedge clk);
                #1;
            end
            cyc = t;

            // ---- compare DUT outputs against the model ----
            in_setup  = inflight && (t == s + 1);
            in_access = inflight && (t >= s + 2) && (t <= s + 2 + w);
            in_resp   = inflight && (t == s + 3 + w);
            if (after_reset) begin
                check_val("rst_paddr",  down_paddr,  '0);
                check_val("rst_pwdata", down_pwdata, '0);
                check_val("rst_pstrb",  down_pstrb,  '0);
                check_val("rst_pprot",  down_pprot,  '0);
                check_val("rst_pwrite", down_pwrite, '0);
                after_reset = 1'b0;
            end
            check_val("busy",         busy,         in_setup || in_access || in_resp);
            check_val("down_psel",    down_psel,    in_setup || in_access);
            check_val("down_penable", down_penable, in_access);
            check_val("grant_id",     grant_id,     exp_grant);
            if (in_setup || in_access) begin
                check_val("down_paddr",  down_paddr,  t_addr);
                check_val("down_pwrite", down_pwrite, t_write);
                check_val("down_pwdata", down_pwdata, t_wdata);
                check_val("down_pstrb",  down_pstrb,  t_strb);
                check_val("down_pprot",  down_pprot,  t_prot);
            end
            exp_rdy = '0;
            exp_err = '0;
            for (int i = 0; i < NR; i++) begin
                bit mine;
                mine = in_resp && (i == g);
                exp_rdy[i] = mine;
                exp_err[i] = mine && resp_err;
                check_val($sformatf("up_prdata[%0d]", i), up_prdata[i], mine ? resp_data : 32'h0);
            end
            check_val("up_pready",  up_pready,  exp_rdy);
            check_val("up_pslverr", up_pslverr, exp_err);
`ifdef APB_ARB_TIMEOUT_EN
            check_val("timeout_flag", timeout_flag, 1'b0);
`endif

            // ---- model bookkeeping ----
            // The requester saw pready in the previous cycle and may now move on.
            if (release_req >= 0) begin
                act[release_req] = 1'b0;
                release_req = -1;
            end
            hold = -1;
            if (in_resp) begin
                hold        = g;
                release_req = g;
                inflight    = 1'b0;
                aborted     = 1'b0;
                next_idle   = t + 1;
            end

            rst_now = (t > 20) && ($urandom_range(0, 199) == 0);
            rst = rst_now;

            // ---- requesters ----
            for (int i = 0; i < NR; i++) begin
                if (i == hold) continue;
                if (act[i]) begin
                    if (inflight && i == g && t > s && !aborted && $urandom_range(0, 59) == 0) begin
                        act[i]  = 1'b0;
                        aborted = 1'b1;
                    end else begin
                        age[i]++;
                    end
                end else if (t == 0 && i == 0) begin
                    new_txn(0);
                    m_addr[0] = 16'h0404; m_write[0] = 1'b1;
                    m_wdata[0] = 32'h1234_5678; m_strb[0] = 4'hF;
                end else if (t >= 4 && !(inflight && i == g) && $urandom_range(0, 2) == 0) begin
                    new_txn(i);
                end
            end
            for (int i = 0; i < NR; i++) begin
                up_psel[i]    = act[i];
                up_penable[i] = act[i] && (age[i] > 0);
                if (act[i]) begin
                    up_paddr[i] = m_addr[i]; up_pwrite[i] = m_write[i];
                    up_pwdata[i] = m_wdata[i]; up_pstrb[i] = m_strb[i]; up_pprot[i] = m_prot[i];
                end else begin
                    up_paddr[i] = AW'($urandom); up_pwrite[i] = 1'($urandom);
                    up_pwdata[i] = $urandom; up_pstrb[i] = 4'($urandom); up_pprot[i] = 3'($urandom);
                end
            end

            // ---- downstream completer ----
            down_prdata  = $urandom;
            down_pslverr = 1'($urandom);
            if (in_access) begin
                down_pready = (t == s + 2 + w);
                if (down_pready) begin
                    resp_data = down_prdata;
                    resp_err  = down_pslverr;
                end
            end else begin
                down_pready = 1'($urandom);
            end

            // ---- reset or arbitration ----
            if (rst_now) begin
                inflight    = 1'b0;
                aborted     = 1'b0;
                last_g      = NR - 1;
                exp_grant   = 0;
                next_idle   = t + 1;
                after_reset = 1'b1;
            end else if (!inflight && t >= next_idle) begin
                for (int i = 0; i < NR; i++) rv[i] = act[i];
                if (rv != '0) begin
                    g  = rr_pick(rv, last_g);
                    s  = t;
                    w  = (t == 0) ? 0 : (($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3));
                    t_addr = m_addr[g]; t_write = m_write[g]; t_wdata = m_wdata[g];
                    t_strb = m_strb[g]; t_prot = m_prot[g];
                    inflight  = 1'b1;
                    aborted   = 1'b0;
                    last_g    = g;
                    exp_grant = g;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
